inst_fetch_ras: RTL and testbench

- Next-generation program counter for the basic_proc fetch stage. Adds parametrised PC width, per-program start vectors, stall, and call/return through a hardware return-address stack (RAS). Stack faults are detected and reported.
- Sits between the control decoder and the instruction ROM. ProgCtr drives the ROM address directly.

---
 rtl/inst_fetch_ras.sv | 125 ++++++++++++
 tb/tb_inst_fetch_ras.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ras.sv
// inst_fetch_ras: fetch-stage program counter with per-program start vectors, stall and a return-address stack.
// Define IF_HALT_DETECT_EN to add the Halted output (sticky jump-to-self detection).
module inst_fetch_ras #(
    parameter int PC_W        = 10,
    parameter int RAS_DEPTH   = 4,
    parameter int NUM_PROGS   = 3,
    parameter int PSEL_W      = 2,
    parameter int PROG_STRIDE = 256
) (
    input  logic                             Clk,
    input  logic                             Reset_n,
    input  logic                             Start,
    input  logic [PSEL_W-1:0]                ProgSel,
    input  logic                             Stall,
    input  logic                             Jump,
    input  logic                             BranchAbsOrRel,
    input  logic                             Call,
    input  logic                             Ret,
    input  logic [PC_W-1:0]                  Target,
    output logic [PC_W-1:0]                  ProgCtr,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   StackDepth,
    output logic                             Fault,
    output logic [1:0]                       FaultCode
`ifdef IF_HALT_DETECT_EN
    ,
    output logic                             Halted
`endif
);

    localparam int DW = $clog2(RAS_DEPTH + 1);
    localparam int IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [DW-1:0] FULL = DW'(RAS_DEPTH);

    typedef enum logic [1:0] {RUN, HOLD, FAULT} state_t;

    state_t          state;
    logic [PC_W-1:0] ras [RAS_DEPTH];
    logic [PC_W-1:0] base;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc_inc;
    logic [IW-1:0]   push_idx;
    logic [IW-1:0]   top_idx;
    logic            active;
    logic            do_push;

    // Out-of-range program selects fall back to program 0 at address 0.
    always_comb begin
        base = '0;
        if (int'(ProgSel) < NUM_PROGS)
            base = PC_W'(int'(ProgSel) * PROG_STRIDE);
        target   = BranchAbsOrRel ? ProgCtr + Target : Target;
        pc_inc   = ProgCtr + PC_W'(1);
        push_idx = IW'(StackDepth);
        top_idx  = push_idx - IW'(1);
        active   = !Start && (state != FAULT) && !Stall;
        do_push  = active && Call && !Ret && (StackDepth != FULL);
    end

    always_ff @(posedge Clk) begin
        if (do_push)
            ras[push_idx] <= pc_inc;
    end

    // HOLD behaves exactly like RUN once Start drops, so both share the run path below.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= RUN;
            ProgCtr    <= '0;
            StackDepth <= '0;
            Fault      <= 1'b0;
            FaultCode  <= 2'b00;
`ifdef IF_HALT_DETECT_EN
            Halted     <= 1'b0;
`endif
        end else if (Start) begin
            state      <= HOLD;
            ProgCtr    <= base;
            StackDepth <= '0;
            Fault      <= 1'b0;
            FaultCode  <= 2'b00;
`ifdef IF_HALT_DETECT_EN
            Halted     <= 1'b0;
`endif
        end else if (state == FAULT) begin
            state <= FAULT;
        end else if (Stall) begin
            state <= RUN;
        end else if (Call && Ret) begin
            state     <= FAULT;
            Fault     <= 1'b1;
            FaultCode <= 2'b11;
        end else if (Ret) begin
            if (StackDepth == '0) begin
                state     <= FAULT;
                Fault     <= 1'b1;
                FaultCode <= 2'b10;
            end else begin
                state      <= RUN;
                ProgCtr    <= ras[top_idx];
                StackDepth <= StackDepth - DW'(1);
            end
        end else if (Call) begin
            if (StackDepth == FULL) begin
                state     <= FAULT;
                Fault     <= 1'b1;
                FaultCode <= 2'b01;
            end else begin
                state      <= RUN;
                ProgCtr    <= target;
                StackDepth <= StackDepth + DW'(1);
            end
        end else if (Jump) begin
            state   <= RUN;
            ProgCtr <= target;
`ifdef IF_HALT_DETECT_EN
            if (target == ProgCtr)
                Halted <= 1'b1;
`endif
        end else begin
            state   <= RUN;
            ProgCtr <= pc_inc;
        end
    end

endmodule

// File: tb/tb_inst_fetch_ras.sv
// Directed self-checking bench for inst_fetch_ras (default parameters).
// Halt detection checks are compiled in when IF_HALT_DETECT_EN is defined.
module tb_inst_fetch_ras;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Start;
    logic [1:0] ProgSel;
    logic       Stall;
    logic       Jump;
    logic       BranchAbsOrRel;
    logic       Call;
    logic       Ret;
    logic [9:0] Target;
    logic [9:0] ProgCtr;
    logic [2:0] StackDepth;
    logic       Fault;
    logic [1:0] FaultCode;
`ifdef IF_HALT_DETECT_EN
    logic       Halted;
`endif

    int total = 0;
    int bad   = 0;

    inst_fetch_ras dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .Start          (Start),
        .ProgSel        (ProgSel),
        .Stall          (Stall),
        .Jump           (Jump),
        .BranchAbsOrRel (BranchAbsOrRel),
        .Call           (Call),
        .Ret            (Ret),
        .Target         (Target),
        .ProgCtr        (ProgCtr),
        .StackDepth     (StackDepth),
        .Fault          (Fault),
        .FaultCode      (FaultCode)
`ifdef IF_HALT_DETECT_EN
        ,
        .Halted         (Halted)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic idle();
        Start = 0; Stall = 0; Jump = 0; BranchAbsOrRel = 0;
        Call = 0; Ret = 0; Target = '0;
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic restart(input logic [1:0] sel);
        idle();
        Start = 1; ProgSel = sel;
        tick();
        Start = 0;
    endtask

    task automatic test_reset();
        idle();
        ProgSel = 0;
        Reset_n = 0;
        #12;
        total++;
        if (ProgCtr !== 10'h000 || StackDepth !== 3'd0 || Fault !== 1'b0 || FaultCode !== 2'b00) begin
            bad++;
            $display("FAIL reset_initial pc=%h depth=%0d fault=%b code=%b, want 000/0/0/00", ProgCtr, StackDepth, Fault, FaultCode);
        end
        @(negedge Clk);
        Reset_n = 1;
        restart(2'd0);
        Call = 1; Target = 10'h030;
        tick();
        Target = 10'h05A;
        tick();
        idle();
        total++;
        if (ProgCtr !== 10'h05A || StackDepth !== 3'd2) begin
            bad++;
            $display("FAIL reset_setup pc=%h depth=%0d, want 05a/2", ProgCtr, StackDepth);
        end
        #3;
        Reset_n = 0;
        #1;
        total++;
        if (ProgCtr !== 10'h000 || StackDepth !== 3'd0 || Fault !== 1'b0) begin
            bad++;
            $display("FAIL reset_async pc=%h depth=%0d fault=%b, want 000/0/0", ProgCtr, StackDepth, Fault);
        end
        @(negedge Clk);
        Reset_n = 1;
    endtask

    task automatic test_start_hold();
        idle();
        Start = 1; ProgSel = 2'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (ProgCtr !== 10'h100) begin
                bad++;
                $display("FAIL hold_cycle%0d pc=%h, want 100", i, ProgCtr);
            end
        end
        Start = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++;
            if (ProgCtr !== 10'h100 + 10'(i)) begin
                bad++;
                $display("FAIL run_step%0d pc=%h, want %h", i, ProgCtr, 10'h100 + 10'(i));
            end
        end
        Start = 1; ProgSel = 2'd2;
        tick();
        total++;
        if (ProgCtr !== 10'h200) begin
            bad++;
            $display("FAIL base_prog2 pc=%h, want 200", ProgCtr);
        end
        ProgSel = 2'd3;
        tick();
        total++;
        if (ProgCtr !== 10'h000 || StackDepth !== 3'd0) begin
            bad++;
            $display("FAIL base_prog3 pc=%h depth=%0d, want 000/0", ProgCtr, StackDepth);
        end
        Start = 0;
    endtask

    task automatic test_call_ret();
        logic [9:0] exp_pc [5] = '{10'h040, 10'h041, 10'h042, 10'h043, 10'h011};
        logic [2:0] exp_d  [5] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
        idle();
        Jump = 1; Target = 10'h010;
        tick();
        total++;
        if (ProgCtr !== 10'h010) begin
            bad++;
            $display("FAIL jump_abs pc=%h, want 010", ProgCtr);
        end
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i == 0) begin Call = 1; Target = 10'h040; end
            if (i == 4) Ret = 1;
            tick();
            total++;
            if (ProgCtr !== exp_pc[i] || StackDepth !== exp_d[i] || Fault !== 1'b0) begin
                bad++;
                $display("FAIL call_ret_step%0d pc=%h depth=%0d fault=%b, want %h/%0d/0", i, ProgCtr, StackDepth, Fault, exp_pc[i], exp_d[i]);
            end
        end
        idle();
    endtask

    task automatic test_rel_wrap_stall();
        idle();
        Jump = 1; Target = 10'h3FE;
        tick();
        BranchAbsOrRel = 1; Target = 10'h3FC;
        tick();
        total++;
        if (ProgCtr !== 10'h3FA) begin
            bad++;
            $display("FAIL jump_rel_neg pc=%h, want 3fa", ProgCtr);
        end
        BranchAbsOrRel = 0; Target = 10'h3FF;
        tick();
        idle();
        tick();
        total++;
        if (ProgCtr !== 10'h000) begin
            bad++;
            $display("FAIL inc_wrap pc=%h, want 000", ProgCtr);
        end
        Call = 1; Target = 10'h100;
        tick();
        idle();
        Stall = 1; Jump = 1; Target = 10'h222;
        tick();
        total++;
        if (ProgCtr !== 10'h100 || StackDepth !== 3'd1) begin
            bad++;
            $display("FAIL stall_jump pc=%h depth=%0d, want 100/1", ProgCtr, StackDepth);
        end
        Jump = 0; Ret = 1;
        tick();
        total++;
        if (ProgCtr !== 10'h100 || StackDepth !== 3'd1) begin
            bad++;
            $display("FAIL stall_ret pc=%h depth=%0d, want 100/1", ProgCtr, StackDepth);
        end
        idle();
        tick();
        total++;
        if (ProgCtr !== 10'h101) begin
            bad++;
            $display("FAIL after_stall pc=%h, want 101", ProgCtr);
        end
        Call = 1; BranchAbsOrRel = 1; Target = 10'h005;
        tick();
        total++;
        if (ProgCtr !== 10'h106 || StackDepth !== 3'd2) begin
            bad++;
            $display("FAIL call_rel pc=%h depth=%0d, want 106/2", ProgCtr, StackDepth);
        end
        idle();
        Ret = 1;
        tick();
        total++;
        if (ProgCtr !== 10'h102 || StackDepth !== 3'd1) begin
            bad++;
            $display("FAIL ret_rel pc=%h depth=%0d, want 102/1", ProgCtr, StackDepth);
        end
        idle();
    endtask

    task automatic test_faults();
        restart(2'd0);
        for (int i = 1; i <= 4; i++) begin
            idle();
            Call = 1; Target = 10'(i * 16);
            tick();
        end
        total++;
        if (ProgCtr !== 10'h040 || StackDepth !== 3'd4 || Fault !== 1'b0) begin
            bad++;
            $display("FAIL nest4 pc=%h depth=%0d fault=%b, want 040/4/0", ProgCtr, StackDepth, Fault);
        end
        Target = 10'h050;
        tick();
        total++;
        if (ProgCtr !== 10'h040 || StackDepth !== 3'd4 || Fault !== 1'b1 || FaultCode !== 2'b01) begin
            bad++;
            $display("FAIL overflow pc=%h depth=%0d fault=%b code=%b, want 040/4/1/01", ProgCtr, StackDepth, Fault, FaultCode);
        end
        idle();
        Ret = 1;
        tick();
        total++;
        if (ProgCtr !== 10'h040 || StackDepth !== 3'd4 || Fault !== 1'b1) begin
            bad++;
            $display("FAIL fault_frozen pc=%h depth=%0d fault=%b, want 040/4/1", ProgCtr, StackDepth, Fault);
        end
        idle();
        Start = 1; ProgSel = 2'd0;
        tick();
        total++;
        if (Fault !== 1'b0 || FaultCode !== 2'b00 || StackDepth !== 3'd0 || ProgCtr !== 10'h000) begin
            bad++;
            $display("FAIL start_clears pc=%h depth=%0d fault=%b code=%b, want 000/0/0/00", ProgCtr, StackDepth, Fault, FaultCode);
        end
        Start = 0; Ret = 1;
        tick();
        total++;
        if (Fault !== 1'b1 || FaultCode !== 2'b10 || ProgCtr !== 10'h000) begin
            bad++;
            $display("FAIL underflow pc=%h fault=%b code=%b, want 000/1/10", ProgCtr, Fault, FaultCode);
        end
        restart(2'd0);
        tick();
        Call = 1; Ret = 1; Target = 10'h080;
        tick();
        total++;
        if (Fault !== 1'b1 || FaultCode !== 2'b11 || ProgCtr !== 10'h001 || StackDepth !== 3'd0) begin
            bad++;
            $display("FAIL call_and_ret pc=%h depth=%0d fault=%b code=%b, want 001/0/1/11", ProgCtr, StackDepth, Fault, FaultCode);
        end
        idle();
    endtask

`ifdef IF_HALT_DETECT_EN
    task automatic test_halt();
        restart(2'd0);
        Jump = 1; Target = 10'h020;
        tick();
        total++;
        if (ProgCtr !== 10'h020 || Halted !== 1'b0) begin
            bad++;
            $display("FAIL halt_setup pc=%h halted=%b, want 020/0", ProgCtr, Halted);
        end
        tick();
        total++;
        if (ProgCtr !== 10'h020 || Halted !== 1'b1) begin
            bad++;
            $display("FAIL halt_detect pc=%h halted=%b, want 020/1", ProgCtr, Halted);
        end
        idle();
        tick();
        total++;
        if (ProgCtr !== 10'h021 || Halted !== 1'b1) begin
            bad++;
            $display("FAIL halt_sticky pc=%h halted=%b, want 021/1", ProgCtr, Halted);
        end
        Start = 1; ProgSel = 2'd0;
        tick();
        total++;
        if (Halted !== 1'b0) begin
            bad++;
            $display("FAIL halt_clear halted=%b, want 0", Halted);
        end
        idle();
    endtask
`endif

    initial begin
        test_reset();
        test_start_hold();
        test_call_ret();
        test_rel_wrap_stall();
        test_faults();
`ifdef IF_HALT_DETECT_EN
        test_halt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
